// File: rtl/score_keeper.sv
// score_keeper: game-flow FSM (IDLE/PLAY/SERVE/OVER) with a saturating 3-digit BCD score and lives.
// Define SCORE_KEEPER_HISCORE_EN to add the hiscore register and port, which survive rst.
module score_keeper #(
    parameter int LIVES        = 3,
    parameter int SERVE_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic        game_on,
    output logic [1:0]  state,
    output logic [11:0] score,
    output logic [1:0]  lives,
`ifdef SCORE_KEEPER_HISCORE_EN
    output logic [11:0] hiscore,
`endif
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_SERVE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
    localparam logic [25:0] SERVE_LAST = 26'(SERVE_CYCLES - 1);

    // Saturating BCD increment: 999 stays 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h999) begin
            return v;
        end
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    state_t      r_state;
    logic [11:0] r_score;
    logic [1:0]  r_lives;
    logic [25:0] r_serve_cnt;
    logic        r_game_on;
    logic        r_game_over;
    logic        r_start_d;
    logic        r_hit_d;
    logic        r_miss_d;

    logic        w_start_ev;
    logic        w_hit_ev;
    logic        w_miss_ev;
    state_t      w_state_nxt;
    logic [11:0] w_score_nxt;
    logic [1:0]  w_lives_nxt;
    logic [25:0] w_cnt_nxt;

    assign w_start_ev = start & ~r_start_d;
    assign w_hit_ev   = hit   & ~r_hit_d;
    assign w_miss_ev  = miss  & ~r_miss_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_serve_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start_ev) begin
                    w_state_nxt = S_PLAY;
                    w_score_nxt = 12'h000;
                    w_lives_nxt = LIVES_INIT;
                end
            end
            S_PLAY: begin
                // A miss on the same edge as a hit wins; the hit is dropped.
                if (w_miss_ev) begin
                    w_lives_nxt = r_lives - 2'd1;
                    if (r_lives == 2'd1) begin
                        w_state_nxt = S_OVER;
                    end else begin
                        w_state_nxt = S_SERVE;
                        w_cnt_nxt   = 26'd0;
                    end
                end else if (w_hit_ev) begin
                    w_score_nxt = bcd_inc(r_score);
                end
            end
            S_SERVE: begin
                w_cnt_nxt = r_serve_cnt + 26'd1;
                if (r_serve_cnt == SERVE_LAST) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_OVER: begin
                if (w_start_ev) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_score     <= 12'h000;
            r_lives     <= LIVES_INIT;
            r_serve_cnt <= 26'd0;
            r_game_on   <= 1'b0;
            r_game_over <= 1'b0;
            r_start_d   <= 1'b0;
            r_hit_d     <= 1'b0;
            r_miss_d    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_lives     <= w_lives_nxt;
            r_serve_cnt <= w_cnt_nxt;
            r_game_on   <= (w_state_nxt == S_PLAY);
            r_game_over <= (w_state_nxt == S_OVER);
            r_start_d   <= start;
            r_hit_d     <= hit;
            r_miss_d    <= miss;
        end
    end

`ifdef SCORE_KEEPER_HISCORE_EN
    // NOTE: hiscore is deliberately left out of rst; its power-up value comes from the declaration.
    logic [11:0] r_hiscore = 12'h000;

    // Valid BCD digits order the same as binary, so a plain compare is a BCD magnitude compare.
    always_ff @(posedge clk) begin
        if (!rst && (w_state_nxt == S_OVER) && (r_state != S_OVER) && (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign hiscore = r_hiscore;
`endif

    assign state     = r_state;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_on   = r_game_on;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (LIVES=3, SERVE_CYCLES=4): vector table, directed corner
// sequences and randomized stimulus, all checked against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int LIVES        = 3;
    localparam int SERVE_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hit;
    logic        miss;
    logic        game_on;
    logic [1:0]  state;
    logic [11:0] score;
    logic [1:0]  lives;
    logic        game_over;
`ifdef SCORE_KEEPER_HISCORE_EN
    logic [11:0] hiscore;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .LIVES        (LIVES),
        .SERVE_CYCLES (SERVE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hit       (hit),
        .miss      (miss),
        .game_on   (game_on),
        .state     (state),
        .score     (score),
        .lives     (lives),
`ifdef SCORE_KEEPER_HISCORE_EN
        .hiscore   (hiscore),
`endif
        .game_over (game_over)
    );

    // Reference model: phase uses the output encoding, score is a plain integer 0..999,
    // serve_left counts the SERVE cycles still to go.
    int m_phase      = 0;
    int m_score      = 0;
    int m_lives      = LIVES;
    int m_serve_left = 0;
    int m_hiscore    = 0;
    bit m_ps = 0, m_ph = 0, m_pm = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit h, input bit m);
        bit se, he, me;
        if (r) begin
            m_phase = 0; m_score = 0; m_lives = LIVES; m_serve_left = 0;
            m_ps = 0; m_ph = 0; m_pm = 0;
            return;
        end
        se = s && !m_ps;
        he = h && !m_ph;
        me = m && !m_pm;
        case (m_phase)
            0: if (se) begin m_phase = 1; m_score = 0; m_lives = LIVES; end
            1: begin
                if (me) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) begin
                        m_phase = 3;
                        if (m_score > m_hiscore) m_hiscore = m_score;
                    end else begin
                        m_phase = 2;
                        m_serve_left = SERVE_CYCLES;
                    end
                end else if (he && m_score < 999) begin
                    m_score = m_score + 1;
                end
            end
            2: begin
                m_serve_left = m_serve_left - 1;
                if (m_serve_left == 0) m_phase = 1;
            end
            default: if (se) m_phase = 0;
        endcase
        m_ps = s; m_ph = h; m_pm = m;
    endtask

    task automatic compare_model();
        check("model_state", 32'(state), 32'(m_phase));
        check("model_score", 32'(score), 32'(to_bcd(m_score)));
        check("model_lives", 32'(lives), 32'(m_lives));
        check("model_game_on", 32'(game_on), 32'(m_phase == 1));
        check("model_game_over", 32'(game_over), 32'(m_phase == 3));
`ifdef SCORE_KEEPER_HISCORE_EN
        check("model_hiscore", 32'(hiscore), 32'(to_bcd(m_hiscore)));
`endif
    endtask

    // One clock: drive after the falling edge, update model at the rising edge, compare 1 ns later.
    task automatic step(input bit r, input bit s, input bit h, input bit m);
        @(negedge clk);
        rst = r; start = s; hit = h; miss = m;
        @(posedge clk);
        model_edge(r, s, h, m);
        #1;
        compare_model();
    endtask

    task automatic restart();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic pulse_hit();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask

    typedef struct {
        bit          rst, start, hit, miss;
        logic [1:0]  e_state;
        logic [11:0] e_score;
        logic [1:0]  e_lives;
        bit          e_on, e_over;
    } vec_t;

    vec_t vecs[$];
    int   serve_len;
    bit   cur_s, cur_h, cur_m;

    initial begin
        rst = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;

        //                rst s h m  state  score    lives on over
        vecs.push_back(vec_t'{1,0,0,0, 2'd0, 12'h000, 2'd3, 0, 0});
        vecs.push_back(vec_t'{1,0,0,0, 2'd0, 12'h000, 2'd3, 0, 0});
        vecs.push_back(vec_t'{0,1,0,0, 2'd1, 12'h000, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,1,1,0, 2'd1, 12'h001, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,1,0, 2'd1, 12'h001, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd1, 12'h001, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,1,0, 2'd1, 12'h002, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd1, 12'h002, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,1,1, 2'd2, 12'h002, 2'd2, 0, 0});
        vecs.push_back(vec_t'{0,0,1,1, 2'd2, 12'h002, 2'd2, 0, 0});
        vecs.push_back(vec_t'{0,1,0,1, 2'd2, 12'h002, 2'd2, 0, 0});
        vecs.push_back(vec_t'{0,0,1,1, 2'd2, 12'h002, 2'd2, 0, 0});
        vecs.push_back(vec_t'{0,0,0,1, 2'd1, 12'h002, 2'd2, 1, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd1, 12'h002, 2'd2, 1, 0});
        vecs.push_back(vec_t'{0,0,0,1, 2'd2, 12'h002, 2'd1, 0, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd2, 12'h002, 2'd1, 0, 0});
        vecs.push_back(vec_t'{0,0,0,1, 2'd2, 12'h002, 2'd1, 0, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd2, 12'h002, 2'd1, 0, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd1, 12'h002, 2'd1, 1, 0});
        vecs.push_back(vec_t'{0,0,0,1, 2'd3, 12'h002, 2'd0, 0, 1});
        vecs.push_back(vec_t'{0,0,1,0, 2'd3, 12'h002, 2'd0, 0, 1});
        vecs.push_back(vec_t'{0,1,0,0, 2'd0, 12'h002, 2'd0, 0, 0});
        vecs.push_back(vec_t'{0,0,1,1, 2'd0, 12'h002, 2'd0, 0, 0});
        vecs.push_back(vec_t'{0,1,0,0, 2'd1, 12'h000, 2'd3, 1, 0});
        vecs.push_back(vec_t'{0,0,0,0, 2'd1, 12'h000, 2'd3, 1, 0});

`ifdef SCORE_KEEPER_HISCORE_EN
        #1;
        check("hiscore_powerup", 32'(hiscore), 32'h000);
`endif
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].hit, vecs[i].miss);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("vec%0d_score", i), 32'(score), 32'(vecs[i].e_score));
            check($sformatf("vec%0d_lives", i), 32'(lives), 32'(vecs[i].e_lives));
            check($sformatf("vec%0d_game_on", i), 32'(game_on), 32'(vecs[i].e_on));
            check($sformatf("vec%0d_game_over", i), 32'(game_over), 32'(vecs[i].e_over));
        end

        // Long hit pulses count once each, including the 9 -> 10 carry.
        restart();
        for (int k = 0; k < 10; k++) begin
            repeat (100) step(0, 0, 1, 0);
            repeat (3) step(0, 0, 0, 0);
            if (k == 8) check("hit_score_009", 32'(score), 32'h009);
        end
        check("hit_score_010", 32'(score), 32'h010);

        // Held miss: one life lost, SERVE lasts exactly SERVE_CYCLES cycles.
        restart();
        serve_len = 0;
        for (int k = 0; k < 50; k++) begin
            step(0, 0, 0, 1);
            if (state == 2'd2) serve_len++;
            if (k == 0) check("miss_lives_2", 32'(lives), 32'd2);
        end
        check("serve_len_4", 32'(serve_len), 32'd4);
        check("after_serve_play", 32'(state), 32'd1);
        check("held_miss_lives", 32'(lives), 32'd2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("serve_miss_ignored_lives", 32'(lives), 32'd1);
        check("serve_miss_ignored_state", 32'(state), 32'd2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("serve_exit_play", 32'(state), 32'd1);

        // Simultaneous hit and miss at score 005, lives 2.
        restart();
        repeat (5) pulse_hit();
        step(0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0);
        check("pre_tie_score", 32'(score), 32'h005);
        check("pre_tie_lives", 32'(lives), 32'd2);
        step(0, 0, 1, 1);
        check("tie_score", 32'(score), 32'h005);
        check("tie_lives", 32'(lives), 32'd1);
        check("tie_state", 32'(state), 32'd2);

        // Saturation at 999, then game over.
        restart();
        repeat (999) pulse_hit();
        check("score_999", 32'(score), 32'h999);
        pulse_hit();
        check("score_sat_999", 32'(score), 32'h999);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            repeat (5) step(0, 0, 0, 0);
        end
        check("over_state", 32'(state), 32'd3);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_lives", 32'(lives), 32'd0);
`ifdef SCORE_KEEPER_HISCORE_EN
        check("over_hiscore", 32'(hiscore), 32'h999);
`endif
        step(0, 1, 0, 0);
        check("over_to_idle", 32'(state), 32'd0);
        check("idle_score_held", 32'(score), 32'h999);
        check("idle_lives_held", 32'(lives), 32'd0);

        // Reset two cycles into SERVE.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("restart_score_000", 32'(score), 32'h000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("mid_serve", 32'(state), 32'd2);
        step(1, 0, 0, 0);
        check("rst_serve_state", 32'(state), 32'd0);
        check("rst_serve_score", 32'(score), 32'h000);
        check("rst_serve_lives", 32'(lives), 32'd3);
`ifdef SCORE_KEEPER_HISCORE_EN
        check("rst_hiscore_kept", 32'(hiscore), 32'h999);
`endif

        // Randomized play, including occasional reset.
        cur_s = 0; cur_h = 0; cur_m = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) cur_s = !cur_s;
            if ($urandom_range(0, 2) == 0) cur_h = !cur_h;
            if ($urandom_range(0, 15) == 0) cur_m = !cur_m;
            step($urandom_range(0, 299) == 0, cur_s, cur_h, cur_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
